saturn_mem_arbiter: RTL and testbench

SATURN_MEM_ARBITER -- requirements
Module: saturn_mem_arbiter

---
 rtl/saturn_bus_pkg.sv | 23 ++
 rtl/saturn_arb_pick.sv | 32 +++
 rtl/saturn_mem_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_saturn_mem_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/saturn_bus_pkg.sv
// Shared types and defaults for the Saturn nibble-memory arbiter.
package saturn_bus_pkg;

  localparam int unsigned ADDR_W_DFLT = 20;
  localparam int unsigned LEN_W_DFLT  = 4;
  localparam int unsigned NIB_W       = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

  typedef enum logic {
    PORT_F = 1'b0,
    PORT_D = 1'b1
  } port_e;

  function automatic port_e other_port(input port_e p);
    return (p == PORT_D) ? PORT_F : PORT_D;
  endfunction

endpackage

// File: rtl/saturn_arb_pick.sv
// Combinational winner selection between fetch and data ports.
// SATURN_ARB_RR_EN selects alternating winners on contention; otherwise data beats fetch.
module saturn_arb_pick
  import saturn_bus_pkg::*;
(
  input  logic  f_req,
  input  logic  d_req,
  input  port_e last_id,
  output logic  win_vld_c,
  output port_e win_id_c
);

`ifdef SATURN_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  port_e rr_pick;

  always_comb begin
    rr_pick   = other_port(last_id);
    win_vld_c = f_req | d_req;
    win_id_c  = PORT_D;
    if (f_req && !d_req) begin
      win_id_c = PORT_F;
    end else if (f_req && d_req) begin
      win_id_c = RR_EN ? rr_pick : PORT_D;
    end
  end

endmodule

// File: rtl/saturn_mem_arbiter.sv
// Two-port (fetch/data) burst arbiter in front of a synchronous nibble memory.
// Contention policy chosen by SATURN_ARB_RR_EN (see saturn_arb_pick).
module saturn_mem_arbiter
  import saturn_bus_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DFLT,
  parameter int unsigned LEN_W  = LEN_W_DFLT
) (
  input  logic              clk,
  input  logic              reset,
  // fetch port
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  input  logic [LEN_W-1:0]  f_len,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic              f_done,
  output logic [NIB_W-1:0]  f_rdata,
  // data port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LEN_W-1:0]  d_len,
  input  logic [NIB_W-1:0]  d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic              d_wready,
  output logic              d_done,
  output logic [NIB_W-1:0]  d_rdata,
  // memory
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [NIB_W-1:0]  mem_wdata,
  input  logic [NIB_W-1:0]  mem_rdata,
  output logic              busy
);

  arb_state_e        state_q, state_d;
  logic [LEN_W-1:0]  ctr_q, ctr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              we_q, we_d;
  port_e             port_q, port_d;
  port_e             last_q, last_d;
  logic              f_gnt_q, f_gnt_d;
  logic              d_gnt_q, d_gnt_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              f_rvalid_q, f_rvalid_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic              f_done_q, f_done_d;
  logic              d_done_q, d_done_d;
  logic              busy_q, busy_d;

  logic  pick_vld_c;
  port_e pick_id_c;

  saturn_arb_pick u_pick (
    .f_req     (f_req),
    .d_req     (d_req),
    .last_id   (last_q),
    .win_vld_c (pick_vld_c),
    .win_id_c  (pick_id_c)
  );

  // Next-state and next-cycle outputs; every issue is decided one cycle ahead.
  always_comb begin
    state_d    = state_q;
    ctr_d      = ctr_q;
    len_d      = len_q;
    base_d     = base_q;
    we_d       = we_q;
    port_d     = port_q;
    last_d     = last_q;
    f_gnt_d    = f_gnt_q;
    d_gnt_d    = d_gnt_q;
    mem_en_d   = 1'b0;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    f_done_d   = 1'b0;
    d_done_d   = 1'b0;
    // read data returns one cycle after its issue
    f_rvalid_d = mem_en_q && !mem_we_q && (port_q == PORT_F);
    d_rvalid_d = mem_en_q && !mem_we_q && (port_q == PORT_D);

    unique case (state_q)
      IDLE: begin
        if (pick_vld_c) begin
          state_d = XFER;
          port_d  = pick_id_c;
          last_d  = pick_id_c;
          ctr_d   = '0;
          if (pick_id_c == PORT_D) begin
            base_d  = d_addr;
            len_d   = d_len;
            we_d    = d_we;
            d_gnt_d = 1'b1;
          end else begin
            base_d  = f_addr;
            len_d   = f_len;
            we_d    = 1'b0;
            f_gnt_d = 1'b1;
          end
          mem_en_d   = 1'b1;
          mem_we_d   = we_d;
          mem_addr_d = base_d;
        end
      end
      XFER: begin
        if (ctr_q == len_q) begin
          state_d  = DRAIN;
          f_done_d = (port_q == PORT_F);
          d_done_d = (port_q == PORT_D);
        end else begin
          ctr_d      = ctr_q + LEN_W'(1);
          mem_en_d   = 1'b1;
          mem_we_d   = we_q;
          mem_addr_d = base_q + ADDR_W'(ctr_d);
        end
      end
      DRAIN: begin
        state_d = IDLE;
        f_gnt_d = 1'b0;
        d_gnt_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
        f_gnt_d = 1'b0;
        d_gnt_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      ctr_q      <= '0;
      len_q      <= '0;
      base_q     <= '0;
      we_q       <= 1'b0;
      port_q     <= PORT_F;
      last_q     <= PORT_F;
      f_gnt_q    <= 1'b0;
      d_gnt_q    <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      f_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      f_done_q   <= 1'b0;
      d_done_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctr_q      <= ctr_d;
      len_q      <= len_d;
      base_q     <= base_d;
      we_q       <= we_d;
      port_q     <= port_d;
      last_q     <= last_d;
      f_gnt_q    <= f_gnt_d;
      d_gnt_q    <= d_gnt_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      f_rvalid_q <= f_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
      f_done_q   <= f_done_d;
      d_done_q   <= d_done_d;
      busy_q     <= busy_d;
    end
  end

  // Read and write nibbles pass straight through, gated to zero when not valid.
  assign f_rdata   = f_rvalid_q ? mem_rdata : '0;
  assign d_rdata   = d_rvalid_q ? mem_rdata : '0;
  assign mem_wdata = mem_we_q ? d_wdata : '0;
  assign d_wready  = mem_we_q;

  assign f_gnt    = f_gnt_q;
  assign d_gnt    = d_gnt_q;
  assign f_rvalid = f_rvalid_q;
  assign d_rvalid = d_rvalid_q;
  assign f_done   = f_done_q;
  assign d_done   = d_done_q;
  assign mem_en   = mem_en_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_saturn_mem_arbiter.sv
// Scoreboard bench for saturn_mem_arbiter: randomized bursts against a transaction-level model.
module tb_saturn_mem_arbiter;

  logic        clk, reset;
  logic        f_req, f_gnt, f_rvalid, f_done;
  logic [19:0] f_addr;
  logic [3:0]  f_len, f_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid, d_wready, d_done;
  logic [19:0] d_addr;
  logic [3:0]  d_len, d_wdata, d_rdata;
  logic        mem_en, mem_we, busy;
  logic [19:0] mem_addr;
  logic [3:0]  mem_wdata, mem_rdata;

  saturn_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_len(f_len), .f_gnt(f_gnt),
    .f_rvalid(f_rvalid), .f_done(f_done), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_len(d_len), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_wready(d_wready), .d_done(d_done), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {logic [19:0] a; bit we; logic [3:0] wd;} iss_t;
  typedef struct {int len; bit rd;} done_t;

  iss_t        exp_iss[$];
  logic [3:0]  exp_frd[$], exp_drd[$];
  done_t       exp_fdn[$], exp_ddn[$];
  bit          exp_gnt[$];
  logic [3:0]  phys [logic [19:0]];
  logic [3:0]  refm [logic [19:0]];
  logic [3:0]  wd [16];
  bit          last_d;
  int          n_cmp = 0;
  int          n_fail = 0;

  function automatic logic [3:0] init_nib(input logic [19:0] a);
    return a[3:0] ^ a[11:8] ^ a[19:16] ^ 4'h9;
  endfunction

  function void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Environment memory: synchronous, read data one cycle after mem_en.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) phys[mem_addr] = mem_wdata;
      else mem_rdata <= phys.exists(mem_addr) ? phys[mem_addr] : init_nib(mem_addr);
    end
  end

  // Reference model: one whole burst expressed as its expected observable events.
  function void plan(input bit is_d, input logic [19:0] base, input int len, input bit we);
    iss_t it;
    done_t dn;
    logic [3:0] rd;
    exp_gnt.push_back(is_d);
    for (int i = 0; i <= len; i++) begin
      it.a  = base + 20'(i);
      it.we = we;
      it.wd = we ? wd[i] : 4'h0;
      exp_iss.push_back(it);
      if (we) refm[it.a] = wd[i];
      else begin
        rd = refm.exists(it.a) ? refm[it.a] : init_nib(it.a);
        if (is_d) exp_drd.push_back(rd);
        else exp_frd.push_back(rd);
      end
    end
    dn.len = len;
    dn.rd  = !we;
    if (is_d) exp_ddn.push_back(dn);
    else exp_fdn.push_back(dn);
    last_d = is_d;
  endfunction

  function bit pick_d(input bit uf, input bit ud);
    if (!uf) return 1'b1;
    if (!ud) return 1'b0;
`ifdef SATURN_ARB_RR_EN
    return !last_d;
`else
    return 1'b1;
`endif
  endfunction

  function logic [19:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return 20'hFFFF0 | 20'($urandom_range(0, 15));
    return 20'($urandom);
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  bit pf_gnt, pd_gnt, pf_done, pd_done;
  int f_cyc, d_cyc;
  always @(negedge clk) begin
    iss_t it;
    done_t dn;
    if (!reset) begin
      pf_gnt = 0; pd_gnt = 0; pf_done = 0; pd_done = 0; f_cyc = 0; d_cyc = 0;
    end else begin
      if (f_gnt && !pf_gnt) begin
        if (exp_gnt.size() == 0) chk("gnt_q_f", 32'(exp_gnt.size()), 1);
        else chk("gnt_port_f", 0, 32'(exp_gnt.pop_front()));
        f_cyc = 1;
      end else if (f_gnt) f_cyc++;
      if (d_gnt && !pd_gnt) begin
        if (exp_gnt.size() == 0) chk("gnt_q_d", 32'(exp_gnt.size()), 1);
        else chk("gnt_port_d", 1, 32'(exp_gnt.pop_front()));
        d_cyc = 1;
      end else if (d_gnt) d_cyc++;
      chk("dual_gnt", 32'(f_gnt & d_gnt), 0);
      chk("busy", 32'(busy), 32'(f_gnt | d_gnt));

      if (mem_en) begin
        if (exp_iss.size() == 0) chk("issue_q", 32'(exp_iss.size()), 1);
        else begin
          it = exp_iss.pop_front();
          chk("mem_addr", 32'(mem_addr), 32'(it.a));
          chk("mem_we", 32'(mem_we), 32'(it.we));
          chk("d_wready", 32'(d_wready), 32'(it.we));
          if (it.we) chk("mem_wdata", 32'(mem_wdata), 32'(it.wd));
        end
      end else begin
        chk("idle_mem_we", 32'(mem_we), 0);
        chk("idle_wready", 32'(d_wready), 0);
      end

      if (f_rvalid) begin
        if (exp_frd.size() == 0) chk("f_rd_q", 32'(exp_frd.size()), 1);
        else chk("f_rdata", 32'(f_rdata), 32'(exp_frd.pop_front()));
      end
      if (d_rvalid) begin
        if (exp_drd.size() == 0) chk("d_rd_q", 32'(exp_drd.size()), 1);
        else chk("d_rdata", 32'(d_rdata), 32'(exp_drd.pop_front()));
      end

      if (f_done) begin
        if (exp_fdn.size() == 0) chk("f_done_q", 32'(exp_fdn.size()), 1);
        else begin
          dn = exp_fdn.pop_front();
          chk("f_done_lat", 32'(f_cyc), 32'(dn.len + 2));
          chk("f_done_rv", 32'(f_rvalid), 32'(dn.rd));
        end
      end
      if (d_done) begin
        if (exp_ddn.size() == 0) chk("d_done_q", 32'(exp_ddn.size()), 1);
        else begin
          dn = exp_ddn.pop_front();
          chk("d_done_lat", 32'(d_cyc), 32'(dn.len + 2));
          chk("d_done_rv", 32'(d_rvalid), 32'(dn.rd));
        end
      end
      if (pf_done) chk("f_gnt_drop", 32'(f_gnt), 0);
      if (pd_done) chk("d_gnt_drop", 32'(d_gnt), 0);

      pf_gnt = f_gnt; pd_gnt = d_gnt; pf_done = f_done; pd_done = d_done;
    end
  end

  // Drive one job (one or two requesters) from plan to completion; entered at posedge+1.
  task automatic run_job(input bit uf, input bit ud,
                         input logic [19:0] fa, input logic [3:0] fl,
                         input logic [19:0] da, input logic [3:0] dl, input bit dwe,
                         input bit scramble, input bit early_drop);
    bit first_d, fdone, ddone, sw, sfd, sdd, sfg, sdg;
    int cyc, wcnt;
    if (uf && ud) begin
      first_d = pick_d(1'b1, 1'b1);
      if (first_d) begin plan(1'b1, da, int'(dl), dwe); plan(1'b0, fa, int'(fl), 1'b0); end
      else begin plan(1'b0, fa, int'(fl), 1'b0); plan(1'b1, da, int'(dl), dwe); end
    end else if (uf) plan(1'b0, fa, int'(fl), 1'b0);
    else plan(1'b1, da, int'(dl), dwe);

    f_req = uf; f_addr = fa; f_len = fl;
    d_req = ud; d_addr = da; d_len = dl; d_we = dwe;
    wcnt = 0; d_wdata = wd[0];
    fdone = !uf; ddone = !ud; cyc = 0;
    while (!(fdone && ddone) && cyc < 200) begin
      @(negedge clk);
      sw = d_wready; sfd = f_done; sdd = d_done; sfg = f_gnt; sdg = d_gnt;
      @(posedge clk); #1;
      cyc++;
      if (sw && wcnt < 15) begin wcnt++; d_wdata = wd[wcnt]; end
      if (scramble && sfg) begin f_addr = 20'($urandom); f_len = 4'($urandom); end
      if (scramble && sdg) begin d_addr = 20'($urandom); d_len = 4'($urandom); d_we = 1'($urandom); end
      if (early_drop && sfg) f_req = 1'b0;
      if (early_drop && sdg) d_req = 1'b0;
      if (sfd) begin f_req = 1'b0; fdone = 1'b1; end
      if (sdd) begin d_req = 1'b0; ddone = 1'b1; end
    end
    chk("job_complete", 32'(fdone && ddone), 1);
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int iss;
    reset = 1'b0;
    f_req = 0; f_addr = '0; f_len = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_len = '0; d_wdata = '0;
    last_d = 1'b0;
    for (int i = 0; i < 16; i++) wd[i] = 4'(i);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_f_gnt", 32'(f_gnt), 0);       chk("rst_d_gnt", 32'(d_gnt), 0);
    chk("rst_f_rvalid", 32'(f_rvalid), 0); chk("rst_d_rvalid", 32'(d_rvalid), 0);
    chk("rst_f_done", 32'(f_done), 0);     chk("rst_d_done", 32'(d_done), 0);
    chk("rst_f_rdata", 32'(f_rdata), 0);   chk("rst_d_rdata", 32'(d_rdata), 0);
    chk("rst_d_wready", 32'(d_wready), 0); chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_mem_we", 32'(mem_we), 0);     chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0); chk("rst_busy", 32'(busy), 0);
    reset = 1'b1;

    // fetch 4-nibble read
    run_job(1, 0, 20'h00100, 4'd3, '0, '0, 0, 0, 0);
    // data write wrapping through FFFFF, then read back
    wd[0] = 4'h1; wd[1] = 4'h2; wd[2] = 4'h3;
    run_job(0, 1, '0, '0, 20'hFFFFE, 4'd2, 1, 0, 0);
    run_job(0, 1, '0, '0, 20'hFFFFE, 4'd2, 0, 0, 0);
    // simultaneous requests, twice
    run_job(1, 1, 20'h00200, 4'd1, 20'h00300, 4'd2, 0, 0, 0);
    run_job(1, 1, 20'h00400, 4'd2, 20'h00500, 4'd1, 0, 0, 0);
    // single-nibble read, request dropped on the grant cycle
    run_job(1, 0, 20'h12345, 4'd0, '0, '0, 0, 0, 1);

    for (int j = 0; j < 60; j++) begin
      int mode;
      mode = $urandom_range(0, 2);
      for (int i = 0; i < 16; i++) wd[i] = 4'($urandom);
      run_job(mode != 1, mode != 0, rand_addr(), 4'($urandom), rand_addr(), 4'($urandom),
              1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0);
    end

    // reset during the second nibble of a 16-nibble read
    plan(1'b0, 20'h3A000, 15, 1'b0);
    f_req = 1; f_addr = 20'h3A000; f_len = 4'd15;
    iss = 0;
    for (int k = 0; k < 20 && iss < 2; k++) begin
      @(posedge clk); #1;
      if (mem_en) iss++;
    end
    chk("abort_reach", 32'(iss), 2);
    reset = 1'b0;
    #1;
    chk("abort_mem_en", 32'(mem_en), 0);
    chk("abort_f_gnt", 32'(f_gnt), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_f_done", 32'(f_done), 0);
    chk("abort_f_rvalid", 32'(f_rvalid), 0);
    f_req = 0;
    exp_iss.delete(); exp_frd.delete(); exp_drd.delete();
    exp_fdn.delete(); exp_ddn.delete(); exp_gnt.delete();
    last_d = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_hold_done", 32'(f_done), 0);
      chk("rst_hold_en", 32'(mem_en), 0);
    end
    reset = 1'b1;
    repeat (4) begin @(posedge clk); #1; end

    // contention right after reset
    run_job(1, 1, 20'h00777, 4'd1, 20'h00888, 4'd1, 0, 0, 0);
    repeat (4) begin @(posedge clk); #1; end

    chk("left_issue", 32'(exp_iss.size()), 0);
    chk("left_frd", 32'(exp_frd.size()), 0);
    chk("left_drd", 32'(exp_drd.size()), 0);
    chk("left_fdone", 32'(exp_fdn.size()), 0);
    chk("left_ddone", 32'(exp_ddn.size()), 0);
    chk("left_gnt", 32'(exp_gnt.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
